// File: rtl/sobel_pipe.sv
// Column-streaming Sobel edge stage with a 3-column window; LANES rows per cycle, ROWS/LANES cycles per column.
// Accepts a column only in S_FIRST/S_NEXT; the edge column is held stable until the downstream takes it.
module sobel_pipe #(
    parameter int          ROWS   = 256,
    parameter int          PW     = 8,
    parameter int          LANES  = 16,
    parameter logic [10:0] THRESH = 11'd64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               data_rdy_in,
    input  logic [ROWS*PW-1:0] data_in,
    input  logic               last_col_in,
    output logic               data_req_out,
    output logic               data_rdy_out,
    output logic [ROWS-1:0]    data_out,
    output logic               last_col_out,
    input  logic               data_req_in
);

    localparam int NCHUNK = ROWS / LANES;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {S_FIRST, S_NEXT, S_COMP, S_OUT} state_t;

    state_t             state, state_nxt;
    logic [ROWS*PW-1:0] win_prev, win_cur, win_next;
    logic [ROWS-1:0]    edge_q;
    logic [CW-1:0]      chunk;
    logic               last_pend;
    logic               pad_next;
    logic [LANES-1:0]   lane_edge;
    logic               in_xfer, out_xfer;

    // Out-of-image rows read as zero; columns outside the image are zero-filled in the window.
    function automatic logic [10:0] px(input logic [ROWS*PW-1:0] col, input int r);
        if (r < 0 || r >= ROWS)
            return 11'd0;
        return 11'(col[r*PW +: PW]);
    endfunction

    function automatic logic sobel_bit(input logic [ROWS*PW-1:0] lc,
                                       input logic [ROWS*PW-1:0] cc,
                                       input logic [ROWS*PW-1:0] rc,
                                       input int r);
        logic [10:0]        s_r, s_l, s_d, s_u;
        logic signed [11:0] gx, gy;
        logic [11:0]        ax, ay;
        s_r = px(rc, r-1) + (px(rc, r) << 1) + px(rc, r+1);
        s_l = px(lc, r-1) + (px(lc, r) << 1) + px(lc, r+1);
        s_d = px(lc, r+1) + (px(cc, r+1) << 1) + px(rc, r+1);
        s_u = px(lc, r-1) + (px(cc, r-1) << 1) + px(rc, r-1);
        gx  = $signed({1'b0, s_r}) - $signed({1'b0, s_l});
        gy  = $signed({1'b0, s_d}) - $signed({1'b0, s_u});
        ax  = gx[11] ? $unsigned(-gx) : $unsigned(gx);
        ay  = gy[11] ? $unsigned(-gy) : $unsigned(gy);
        return 11'(ax + ay) >= THRESH;
    endfunction

    always_comb begin
        lane_edge = '0;
        for (int l = 0; l < LANES; l++)
            lane_edge[l] = sobel_bit(win_prev, win_cur, win_next, int'(chunk) * LANES + l);
    end

    assign in_xfer  = data_req_out & data_rdy_in;
    assign out_xfer = data_rdy_out & data_req_in;
    assign data_out = edge_q;

    always_ff @(posedge clock) begin
        if (reset)
            state <= S_FIRST;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        data_req_out = 1'b0;
        case (state)
            S_FIRST: begin
                data_req_out = 1'b1;
                if (data_rdy_in)
                    state_nxt = last_col_in ? S_COMP : S_NEXT;
            end
            S_NEXT: begin
                data_req_out = 1'b1;
                if (data_rdy_in)
                    state_nxt = S_COMP;
            end
            S_COMP: begin
                if (chunk == LAST_CHUNK)
                    state_nxt = S_OUT;
            end
            S_OUT: begin
                if (out_xfer) begin
                    if (last_col_out)
                        state_nxt = S_FIRST;
                    else if (last_pend)
                        state_nxt = S_COMP;
                    else
                        state_nxt = S_NEXT;
                end
            end
            default: state_nxt = S_FIRST;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            win_prev     <= '0;
            win_cur      <= '0;
            win_next     <= '0;
            edge_q       <= '0;
            chunk        <= '0;
            last_pend    <= 1'b0;
            pad_next     <= 1'b0;
            data_rdy_out <= 1'b0;
            last_col_out <= 1'b0;
        end else begin
            case (state)
                S_FIRST: begin
                    if (in_xfer) begin
                        win_prev <= '0;
                        win_cur  <= data_in;
                        chunk    <= '0;
                        if (last_col_in) begin
                            win_next  <= '0;
                            last_pend <= 1'b1;
                            pad_next  <= 1'b1;
                        end
                    end
                end
                S_NEXT: begin
                    if (in_xfer) begin
                        win_next  <= data_in;
                        last_pend <= last_col_in;
                        pad_next  <= 1'b0;
                        chunk     <= '0;
                    end
                end
                S_COMP: begin
                    for (int l = 0; l < LANES; l++)
                        edge_q[int'(chunk) * LANES + l] <= lane_edge[l];
                    if (chunk == LAST_CHUNK) begin
                        chunk        <= '0;
                        data_rdy_out <= 1'b1;
                        // Only a padded (flush) compute produces the frame's last column.
                        last_col_out <= last_pend & pad_next;
                    end else begin
                        chunk <= chunk + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_xfer) begin
                        data_rdy_out <= 1'b0;
                        if (last_col_out) begin
                            win_prev  <= '0;
                            win_cur   <= '0;
                            win_next  <= '0;
                            last_pend <= 1'b0;
                            pad_next  <= 1'b0;
                        end else if (last_pend) begin
                            win_prev <= win_cur;
                            win_cur  <= win_next;
                            win_next <= '0;
                            pad_next <= 1'b1;
                        end else begin
                            win_prev <= win_cur;
                            win_cur  <= win_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_pipe.sv
// Randomized and directed bench for sobel_pipe against a frame-level Sobel reference model.
module tb_sobel_pipe;

    localparam int ROWS  = 256;
    localparam int PW    = 8;
    localparam int LANES = 16;
    localparam int NCH   = ROWS / LANES;
    localparam int TH    = 64;
    localparam int MAXC  = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               data_rdy_in = 1'b0;
    logic [ROWS*PW-1:0] data_in = '0;
    logic               last_col_in = 1'b0;
    logic               data_req_out;
    logic               data_rdy_out;
    logic [ROWS-1:0]    data_out;
    logic               last_col_out;
    logic               data_req_in = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int frm [MAXC][ROWS];
    int acc_q[$];

    sobel_pipe #(.ROWS(ROWS), .PW(PW), .LANES(LANES), .THRESH(11'd64)) dut (
        .clock        (clock),
        .reset        (reset),
        .data_rdy_in  (data_rdy_in),
        .data_in      (data_in),
        .last_col_in  (last_col_in),
        .data_req_out (data_req_out),
        .data_rdy_out (data_rdy_out),
        .data_out     (data_out),
        .last_col_out (last_col_out),
        .data_req_in  (data_req_in)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [ROWS-1:0] got, input logic [ROWS-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pix(input int c, input int r, input int n);
        if (c < 0 || c >= n || r < 0 || r >= ROWS)
            return 0;
        return frm[c][r];
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Expected edge column c of an n-column frame, straight from the Sobel kernels.
    function automatic logic [ROWS-1:0] model(input int c, input int n);
        logic [ROWS-1:0] e;
        int gx, gy;
        e = '0;
        for (int r = 0; r < ROWS; r++) begin
            gx = (pix(c+1, r-1, n) + 2*pix(c+1, r, n) + pix(c+1, r+1, n))
               - (pix(c-1, r-1, n) + 2*pix(c-1, r, n) + pix(c-1, r+1, n));
            gy = (pix(c-1, r+1, n) + 2*pix(c, r+1, n) + pix(c+1, r+1, n))
               - (pix(c-1, r-1, n) + 2*pix(c, r-1, n) + pix(c+1, r-1, n));
            e[r] = (iabs(gx) + iabs(gy)) >= TH;
        end
        return e;
    endfunction

    task automatic send_col(input int c, input bit last);
        bit sent;
        sent = 1'b0;
        for (int r = 0; r < ROWS; r++)
            data_in[r*PW +: PW] = PW'(frm[c][r]);
        last_col_in = last;
        data_rdy_in = 1'b1;
        for (int w = 0; w < 400 && !sent; w++) begin
            if (data_req_out) begin
                @(posedge clock); #1;
                acc_q.push_back(cyc);
                sent = 1'b1;
            end else begin
                @(posedge clock); #1;
            end
        end
        data_rdy_in = 1'b0;
        last_col_in = 1'b0;
        if (!sent)
            check($sformatf("send_timeout col%0d", c), ROWS'(data_req_out), ROWS'(1));
    endtask

    task automatic send_frame(input int n);
        for (int c = 0; c < n; c++)
            send_col(c, c == n-1);
    endtask

    task automatic collect(input int n, input int bp_col);
        int last_x;
        int en;
        last_x = 0;
        for (int c = 0; c < n; c++) begin
            for (int w = 0; w < 400 && !data_rdy_out; w++) begin
                @(posedge clock); #1;
            end
            if (!data_rdy_out) begin
                check($sformatf("out_timeout col%0d", c), ROWS'(data_rdy_out), ROWS'(1));
                return;
            end
            if (c < n-1)
                en = (acc_q.size() > c+1) ? acc_q[c+1] : -1000;
            else if (n == 1)
                en = (acc_q.size() > 0) ? acc_q[0] : -1000;
            else
                en = last_x;
            check($sformatf("latency col%0d", c), ROWS'(cyc - en), ROWS'(NCH));
            if (c == bp_col) begin
                data_req_in = 1'b0;
                for (int h = 0; h < 10; h++) begin
                    @(posedge clock); #1;
                    check($sformatf("bp_rdy h%0d", h), ROWS'(data_rdy_out), ROWS'(1));
                    check($sformatf("bp_hold h%0d", h), data_out, model(c, n));
                    check($sformatf("bp_req h%0d", h), ROWS'(data_req_out), ROWS'(0));
                end
                data_req_in = 1'b1;
            end
            check($sformatf("edges col%0d", c), data_out, model(c, n));
            check($sformatf("last col%0d", c), ROWS'(last_col_out), ROWS'(c == n-1));
            @(posedge clock); #1;
            last_x = cyc;
            check($sformatf("rdy_drop col%0d", c), ROWS'(data_rdy_out), ROWS'(0));
        end
    endtask

    task automatic run_frame(input string name, input int n, input int bp_col);
        acc_q.delete();
        fork
            send_frame(n);
            collect(n, bp_col);
        join
        check($sformatf("%s idle_req", name), ROWS'(data_req_out), ROWS'(1));
    endtask

    task automatic fill_const(input int n, input int v);
        for (int c = 0; c < n; c++)
            for (int r = 0; r < ROWS; r++)
                frm[c][r] = v;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset rdy", ROWS'(data_rdy_out), ROWS'(0));
        check("reset last", ROWS'(last_col_out), ROWS'(0));
        check("reset data", data_out, '0);
        check("reset req", ROWS'(data_req_out), ROWS'(1));
        reset = 1'b0;
        @(posedge clock); #1;

        fill_const(3, 100);
        run_frame("flat", 3, -1);

        for (int c = 0; c < 4; c++)
            for (int r = 0; r < ROWS; r++)
                frm[c][r] = (c < 2) ? 0 : 200;
        run_frame("step", 4, -1);

        for (int v = 15; v <= 16; v++) begin
            for (int c = 0; c < 5; c++)
                for (int r = 0; r < ROWS; r++)
                    frm[c][r] = (r < 128) ? 0 : v;
            run_frame($sformatf("thresh%0d", v), 5, -1);
        end

        fill_const(3, 100);
        run_frame("backpressure", 3, 1);

        frm[0][0] = 0;
        for (int r = 1; r < ROWS; r++)
            frm[0][r] = $urandom_range(0, 255);
        run_frame("single", 1, -1);

        for (int f = 0; f < 5; f++) begin
            int n;
            int hi;
            n  = $urandom_range(1, 6);
            hi = (f % 2 == 0) ? 255 : 20;
            for (int c = 0; c < n; c++)
                for (int r = 0; r < ROWS; r++)
                    frm[c][r] = $urandom_range(0, hi);
            run_frame($sformatf("rand%0d", f), n, (f == 3) ? n-1 : -1);
        end

        // Reset in the middle of a compute, then a clean frame must behave as from power-up.
        fill_const(3, 100);
        acc_q.delete();
        send_col(0, 1'b0);
        send_col(1, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midreset rdy", ROWS'(data_rdy_out), ROWS'(0));
        check("midreset req", ROWS'(data_req_out), ROWS'(1));
        check("midreset data", data_out, '0);
        run_frame("after_reset", 3, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
